// File: rtl/rv0_csr_file.sv
// Machine-mode CSR file for the rv0 core: Zicsr RW/RS/RC access with a registered response,
// 64-bit cycle/instret counters, interrupt pending tracking and trap/mret state update.
module rv0_csr_file #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] HART_ID   = '0,
   parameter logic [31:0]     MVENDORID = '0,
   parameter logic [XLEN-1:0] MARCHID   = '0,
   parameter logic [XLEN-1:0] MIMPID    = '0,
   parameter logic [XLEN-1:0] MISA_VAL  = '0,
   parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            csr_req_i,
   input  logic [1:0]      csr_op_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   output logic            csr_rvalid_o,
   output logic [XLEN-1:0] csr_rdata_o,
   output logic            csr_err_o,
   input  logic            instret_i,
   input  logic [2:0]      irq_i,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_cause_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic [XLEN-1:0] trap_tval_i,
   input  logic            mret_i,
   output logic [XLEN-1:0] trap_vec_o,
   output logic [XLEN-1:0] mepc_o,
   output logic            irq_pending_o
);

   localparam logic [1:0] OP_R  = 2'b00;
   localparam logic [1:0] OP_RW = 2'b01;
   localparam logic [1:0] OP_RS = 2'b10;
   localparam logic [1:0] OP_RC = 2'b11;

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MISA      = 12'h301;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSTATUSH  = 12'h310;
   localparam logic [11:0] A_MCOUNTINH = 12'h320;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MTVAL     = 12'h343;
   localparam logic [11:0] A_MIP       = 12'h344;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;
   localparam logic [11:0] A_MVENDORID = 12'hF11;
   localparam logic [11:0] A_MARCHID   = 12'hF12;
   localparam logic [11:0] A_MIMPID    = 12'hF13;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   localparam bit IS_RV32 = (XLEN == 32);

   logic            mie_bit_q, mpie_bit_q;
   logic [2:0]      mie_q, mip_q;          // {bit 11, bit 7, bit 3}
   logic            cy_inh_q, ir_inh_q;
   logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [63:0]     mcycle_q, minstret_q;

   logic            rvalid_q, err_q;
   logic [XLEN-1:0] rdata_q;

   logic [XLEN-1:0] old_val, wval, mstatus_rd, mie_rd, mip_rd, mtvec_wval;
   logic            addr_hit, csr_err, wr_en;

   assign mstatus_rd = XLEN'({2'b11, 3'b000, mpie_bit_q, 3'b000, mie_bit_q, 3'b000});
   assign mie_rd     = XLEN'({mie_q[2], 3'b000, mie_q[1], 3'b000, mie_q[0], 3'b000});
   assign mip_rd     = XLEN'({mip_q[2], 3'b000, mip_q[1], 3'b000, mip_q[0], 3'b000});

   always_comb begin
      old_val  = '0;
      addr_hit = 1'b1;
      case (csr_addr_i)
         A_MVENDORID:           old_val = XLEN'(MVENDORID);
         A_MARCHID:             old_val = MARCHID;
         A_MIMPID:              old_val = MIMPID;
         A_MHARTID:             old_val = HART_ID;
         A_MISA:                old_val = MISA_VAL;
         A_MSTATUS:             old_val = mstatus_rd;
         A_MSTATUSH:            addr_hit = IS_RV32;
         A_MIE:                 old_val = mie_rd;
         A_MIP:                 old_val = mip_rd;
         A_MTVEC:               old_val = mtvec_q;
         A_MSCRATCH:            old_val = mscratch_q;
         A_MEPC:                old_val = mepc_q;
         A_MCAUSE:              old_val = mcause_q;
         A_MTVAL:               old_val = mtval_q;
         A_MCOUNTINH:           old_val = XLEN'({ir_inh_q, 1'b0, cy_inh_q});
         A_MCYCLE, A_CYCLE:     old_val = mcycle_q[XLEN-1:0];
         A_MINSTRET, A_INSTRET: old_val = minstret_q[XLEN-1:0];
         A_MCYCLEH, A_CYCLEH: begin
            addr_hit = IS_RV32;
            old_val  = IS_RV32 ? XLEN'(mcycle_q[63:32]) : '0;
         end
         A_MINSTRETH, A_INSTRETH: begin
            addr_hit = IS_RV32;
            old_val  = IS_RV32 ? XLEN'(minstret_q[63:32]) : '0;
         end
         default:               addr_hit = 1'b0;
      endcase
   end

   // Any write-type op to the read-only quadrant is illegal even if the address exists.
   assign csr_err = !addr_hit || ((csr_op_i != OP_R) && (csr_addr_i[11:10] == 2'b11));
   // Trap and mret own the architectural state this cycle; a colliding CSR write is dropped.
   assign wr_en   = csr_req_i && (csr_op_i != OP_R) && !csr_err && !trap_i && !mret_i;

   always_comb begin
      wval = old_val;
      case (csr_op_i)
         OP_RW:   wval = csr_wdata_i;
         OP_RS:   wval = old_val | csr_wdata_i;
         OP_RC:   wval = old_val & ~csr_wdata_i;
         default: wval = old_val;
      endcase
   end

   // Reserved vector modes 2/3 leave the current mode in place.
   assign mtvec_wval = {wval[XLEN-1:2], (wval[1] ? mtvec_q[1:0] : wval[1:0])};

   // Handshake: csr_req_i is accepted every cycle (no ready); csr_rvalid_o pulses exactly
   // one cycle after each request with rdata/err for that request.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= csr_req_i;
         err_q    <= csr_req_i && csr_err;
         rdata_q  <= (csr_req_i && !csr_err) ? old_val : '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mie_bit_q  <= 1'b0;
         mpie_bit_q <= 1'b0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else if (trap_i) begin
         mpie_bit_q <= mie_bit_q;
         mie_bit_q  <= 1'b0;
         mepc_q     <= {trap_pc_i[XLEN-1:2], 2'b00};
         mcause_q   <= trap_cause_i;
         mtval_q    <= trap_tval_i;
      end else if (mret_i) begin
         mie_bit_q  <= mpie_bit_q;
         mpie_bit_q <= 1'b1;
      end else if (wr_en) begin
         if (csr_addr_i == A_MSTATUS) begin
            mie_bit_q  <= wval[3];
            mpie_bit_q <= wval[7];
         end
         if (csr_addr_i == A_MEPC)   mepc_q   <= {wval[XLEN-1:2], 2'b00};
         if (csr_addr_i == A_MCAUSE) mcause_q <= wval;
         if (csr_addr_i == A_MTVAL)  mtval_q  <= wval;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mie_q      <= '0;
         mip_q      <= '0;
         mtvec_q    <= {MTVEC_RST[XLEN-1:2], 1'b0, MTVEC_RST[0]};
         mscratch_q <= '0;
         cy_inh_q   <= 1'b0;
         ir_inh_q   <= 1'b0;
      end else begin
         mip_q <= irq_i;
         if (wr_en) begin
            if (csr_addr_i == A_MIE)      mie_q      <= {wval[11], wval[7], wval[3]};
            if (csr_addr_i == A_MTVEC)    mtvec_q    <= mtvec_wval;
            if (csr_addr_i == A_MSCRATCH) mscratch_q <= wval;
            if (csr_addr_i == A_MCOUNTINH) begin
               cy_inh_q <= wval[0];
               ir_inh_q <= wval[2];
            end
         end
      end
   end

   // A write to either half of a counter replaces that half and skips the increment.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         if (wr_en && csr_addr_i == A_MCYCLE)
            mcycle_q[XLEN-1:0] <= wval;
         else if (IS_RV32 && wr_en && csr_addr_i == A_MCYCLEH)
            mcycle_q[63:32] <= wval[31:0];
         else if (!cy_inh_q)
            mcycle_q <= mcycle_q + 64'd1;

         if (wr_en && csr_addr_i == A_MINSTRET)
            minstret_q[XLEN-1:0] <= wval;
         else if (IS_RV32 && wr_en && csr_addr_i == A_MINSTRETH)
            minstret_q[63:32] <= wval[31:0];
         else if (!ir_inh_q)
            minstret_q <= minstret_q + {63'd0, instret_i};
      end
   end

   logic [XLEN-1:0] vec_base, vec_off;
   assign vec_base = {mtvec_q[XLEN-1:2], 2'b00};
   assign vec_off  = {trap_cause_i[XLEN-3:0], 2'b00};

   assign trap_vec_o    = (mtvec_q[0] && trap_cause_i[XLEN-1]) ? vec_base + vec_off : vec_base;
   assign mepc_o        = mepc_q;
   assign irq_pending_o = mie_bit_q && |(mip_q & mie_q);
   assign csr_rvalid_o  = rvalid_q;
   assign csr_rdata_o   = rdata_q;
   assign csr_err_o     = err_q;

endmodule

// File: tb/tb_rv0_csr_file.sv
// Directed bench for rv0_csr_file (XLEN=32, HART_ID=5): CSR ops, WARL, counters,
// interrupts, trap/mret and reset behaviour.
module tb_rv0_csr_file;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        csr_req_i = 1'b0;
   logic [1:0]  csr_op_i = 2'b00;
   logic [11:0] csr_addr_i = 12'h000;
   logic [31:0] csr_wdata_i = '0;
   logic        csr_rvalid_o;
   logic [31:0] csr_rdata_o;
   logic        csr_err_o;
   logic        instret_i = 1'b0;
   logic [2:0]  irq_i = 3'b000;
   logic        trap_i = 1'b0;
   logic [31:0] trap_cause_i = '0;
   logic [31:0] trap_pc_i = '0;
   logic [31:0] trap_tval_i = '0;
   logic        mret_i = 1'b0;
   logic [31:0] trap_vec_o;
   logic [31:0] mepc_o;
   logic        irq_pending_o;

   localparam logic [31:0] MISA_V = 32'h4000_0100;

   int n_tests = 0;
   int n_fail  = 0;
   logic        rv, er;
   logic [31:0] rd;

   rv0_csr_file #(
      .XLEN(32), .HART_ID(32'd5), .MVENDORID(32'h0000_0ABC), .MARCHID(32'd0),
      .MIMPID(32'd0), .MISA_VAL(MISA_V), .MTVEC_RST(32'h0000_2003)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .csr_req_i(csr_req_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
      .csr_wdata_i(csr_wdata_i), .csr_rvalid_o(csr_rvalid_o), .csr_rdata_o(csr_rdata_o),
      .csr_err_o(csr_err_o), .instret_i(instret_i), .irq_i(irq_i), .trap_i(trap_i),
      .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i),
      .mret_i(mret_i), .trap_vec_o(trap_vec_o), .mepc_o(mepc_o), .irq_pending_o(irq_pending_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic do_csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         output logic o_rv, output logic o_er, output logic [31:0] o_rd);
      @(negedge clk_i);
      csr_req_i = 1'b1; csr_op_i = op; csr_addr_i = addr; csr_wdata_i = wd;
      @(negedge clk_i);
      o_rv = csr_rvalid_o; o_er = csr_err_o; o_rd = csr_rdata_o;
      csr_req_i = 1'b0; csr_op_i = 2'b00; csr_wdata_i = '0;
   endtask

   task automatic pulse_instret(input int n);
      @(negedge clk_i);
      instret_i = 1'b1;
      repeat (n) @(negedge clk_i);
      instret_i = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      repeat (3) @(negedge clk_i);
      n_tests++; if ({csr_rvalid_o, csr_err_o, csr_rdata_o} !== 34'd0) begin n_fail++;
         $display("FAIL reset_outputs got %h exp %h", {csr_rvalid_o, csr_err_o, csr_rdata_o}, 34'd0); end
      n_tests++; if ({irq_pending_o, mepc_o} !== 33'd0) begin n_fail++;
         $display("FAIL reset_mepc_irq got %h exp %h", {irq_pending_o, mepc_o}, 33'd0); end
      n_tests++; if (trap_vec_o !== 32'h0000_2000) begin n_fail++;
         $display("FAIL reset_trap_vec got %h exp %h", trap_vec_o, 32'h0000_2000); end
      rst_i = 1'b0;
      do_csr(2'b00, 12'hF14, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'd5}) begin n_fail++;
         $display("FAIL mhartid_read got %h exp %h", {rv, er, rd}, {2'b10, 32'd5}); end
      @(negedge clk_i);
      n_tests++; if (csr_rvalid_o !== 1'b0) begin n_fail++;
         $display("FAIL rvalid_single_cycle got %b exp 0", csr_rvalid_o); end
      do_csr(2'b00, 12'h305, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0000_2001}) begin n_fail++;
         $display("FAIL mtvec_reset got %h exp %h", {rv, er, rd}, {2'b10, 32'h0000_2001}); end
      do_csr(2'b00, 12'h300, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0000_1800}) begin n_fail++;
         $display("FAIL mstatus_reset got %h exp %h", {rv, er, rd}, {2'b10, 32'h0000_1800}); end
      do_csr(2'b00, 12'hF11, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0000_0ABC}) begin n_fail++;
         $display("FAIL mvendorid got %h exp %h", {rv, er, rd}, {2'b10, 32'h0000_0ABC}); end
   endtask

   task automatic test_mscratch();
      do_csr(2'b01, 12'h340, 32'hA5A5_0000, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0}) begin n_fail++;
         $display("FAIL mscratch_rw got %h exp %h", {rv, er, rd}, {2'b10, 32'h0}); end
      do_csr(2'b10, 12'h340, 32'h0000_00FF, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'hA5A5_0000}) begin n_fail++;
         $display("FAIL mscratch_rs got %h exp %h", {rv, er, rd}, {2'b10, 32'hA5A5_0000}); end
      do_csr(2'b11, 12'h340, 32'hA500_0000, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'hA5A5_00FF}) begin n_fail++;
         $display("FAIL mscratch_rc got %h exp %h", {rv, er, rd}, {2'b10, 32'hA5A5_00FF}); end
      do_csr(2'b00, 12'h340, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h00A5_00FF}) begin n_fail++;
         $display("FAIL mscratch_final got %h exp %h", {rv, er, rd}, {2'b10, 32'h00A5_00FF}); end
   endtask

   task automatic test_warl();
      do_csr(2'b01, 12'h300, 32'hFFFF_FFFF, rv, er, rd);
      do_csr(2'b01, 12'h300, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0000_1888}) begin n_fail++;
         $display("FAIL mstatus_warl got %h exp %h", {rv, er, rd}, {2'b10, 32'h0000_1888}); end
      do_csr(2'b01, 12'h304, 32'hFFFF_FFFF, rv, er, rd);
      do_csr(2'b01, 12'h304, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0000_0888}) begin n_fail++;
         $display("FAIL mie_warl got %h exp %h", {rv, er, rd}, {2'b10, 32'h0000_0888}); end
      do_csr(2'b01, 12'h305, 32'h0000_1002, rv, er, rd);
      do_csr(2'b00, 12'h305, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0000_1001}) begin n_fail++;
         $display("FAIL mtvec_mode_kept got %h exp %h", {rv, er, rd}, {2'b10, 32'h0000_1001}); end
      do_csr(2'b01, 12'h341, 32'h0000_1237, rv, er, rd);
      n_tests++; if (mepc_o !== 32'h0000_1234) begin n_fail++;
         $display("FAIL mepc_align got %h exp %h", mepc_o, 32'h0000_1234); end
      do_csr(2'b01, 12'h344, 32'hFFFF_FFFF, rv, er, rd);
      do_csr(2'b00, 12'h344, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0}) begin n_fail++;
         $display("FAIL mip_readonly got %h exp %h", {rv, er, rd}, {2'b10, 32'h0}); end
      do_csr(2'b01, 12'h301, 32'h1234_5678, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, MISA_V}) begin n_fail++;
         $display("FAIL misa_write_ignored got %h exp %h", {rv, er, rd}, {2'b10, MISA_V}); end
      do_csr(2'b01, 12'h310, 32'hFFFF_FFFF, rv, er, rd);
      do_csr(2'b00, 12'h310, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0}) begin n_fail++;
         $display("FAIL mstatush_zero got %h exp %h", {rv, er, rd}, {2'b10, 32'h0}); end
   endtask

   task automatic test_back_to_back_mcycle();
      // write mcycle then mcountinhibit.CY on consecutive cycles: exactly one increment
      @(negedge clk_i);
      csr_req_i = 1'b1; csr_op_i = 2'b01; csr_addr_i = 12'hB00; csr_wdata_i = 32'hFFFF_FFFF;
      @(negedge clk_i);
      n_tests++; if ({csr_rvalid_o, csr_err_o} !== 2'b10) begin n_fail++;
         $display("FAIL b2b_first_resp got %b exp 10", {csr_rvalid_o, csr_err_o}); end
      csr_addr_i = 12'h320; csr_wdata_i = 32'h1;
      @(negedge clk_i);
      n_tests++; if ({csr_rvalid_o, csr_err_o, csr_rdata_o} !== {2'b10, 32'h0}) begin n_fail++;
         $display("FAIL b2b_second_resp got %h exp %h", {csr_rvalid_o, csr_err_o, csr_rdata_o}, {2'b10, 32'h0}); end
      csr_req_i = 1'b0; csr_op_i = 2'b00; csr_wdata_i = '0;
      do_csr(2'b00, 12'hB80, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h1}) begin n_fail++;
         $display("FAIL mcycleh_carry got %h exp %h", {rv, er, rd}, {2'b10, 32'h1}); end
      do_csr(2'b00, 12'hB00, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0}) begin n_fail++;
         $display("FAIL mcycle_wrapped got %h exp %h", {rv, er, rd}, {2'b10, 32'h0}); end
      repeat (4) @(negedge clk_i);
      do_csr(2'b00, 12'hC00, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0}) begin n_fail++;
         $display("FAIL cycle_frozen got %h exp %h", {rv, er, rd}, {2'b10, 32'h0}); end
      do_csr(2'b00, 12'hC80, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h1}) begin n_fail++;
         $display("FAIL cycleh_shadow got %h exp %h", {rv, er, rd}, {2'b10, 32'h1}); end
   endtask

   task automatic test_minstret();
      do_csr(2'b00, 12'hB02, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0}) begin n_fail++;
         $display("FAIL minstret_zero got %h exp %h", {rv, er, rd}, {2'b10, 32'h0}); end
      pulse_instret(3);
      do_csr(2'b00, 12'hB02, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h3}) begin n_fail++;
         $display("FAIL minstret_count got %h exp %h", {rv, er, rd}, {2'b10, 32'h3}); end
      do_csr(2'b01, 12'h320, 32'hFFFF_FFFF, rv, er, rd);
      do_csr(2'b00, 12'h320, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h5}) begin n_fail++;
         $display("FAIL mcountinhibit_warl got %h exp %h", {rv, er, rd}, {2'b10, 32'h5}); end
      pulse_instret(2);
      do_csr(2'b00, 12'hC02, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h3}) begin n_fail++;
         $display("FAIL instret_inhibited got %h exp %h", {rv, er, rd}, {2'b10, 32'h3}); end
      do_csr(2'b01, 12'h320, 32'h0, rv, er, rd);
   endtask

   task automatic test_irq_trap();
      do_csr(2'b01, 12'h300, 32'h0000_0008, rv, er, rd);
      do_csr(2'b01, 12'h304, 32'h0000_0080, rv, er, rd);
      n_tests++; if (irq_pending_o !== 1'b0) begin n_fail++;
         $display("FAIL irq_idle got %b exp 0", irq_pending_o); end
      @(negedge clk_i);
      irq_i = 3'b010;
      repeat (2) @(negedge clk_i);
      n_tests++; if (irq_pending_o !== 1'b1) begin n_fail++;
         $display("FAIL irq_pending got %b exp 1", irq_pending_o); end
      do_csr(2'b00, 12'h344, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h80}) begin n_fail++;
         $display("FAIL mip_mtip got %h exp %h", {rv, er, rd}, {2'b10, 32'h80}); end
      @(negedge clk_i);
      trap_cause_i = 32'h0000_0005;
      #1;
      n_tests++; if (trap_vec_o !== 32'h0000_1000) begin n_fail++;
         $display("FAIL trap_vec_exception got %h exp %h", trap_vec_o, 32'h0000_1000); end
      trap_i = 1'b1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h102; trap_tval_i = 32'hDEAD;
      #1;
      n_tests++; if (trap_vec_o !== 32'h0000_101C) begin n_fail++;
         $display("FAIL trap_vec_vectored got %h exp %h", trap_vec_o, 32'h0000_101C); end
      @(negedge clk_i);
      trap_i = 1'b0; trap_cause_i = '0;
      n_tests++; if ({irq_pending_o, mepc_o} !== {1'b0, 32'h100}) begin n_fail++;
         $display("FAIL trap_mepc got %h exp %h", {irq_pending_o, mepc_o}, {1'b0, 32'h100}); end
      do_csr(2'b00, 12'h300, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0000_1880}) begin n_fail++;
         $display("FAIL trap_mstatus got %h exp %h", {rv, er, rd}, {2'b10, 32'h0000_1880}); end
      do_csr(2'b00, 12'h342, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h8000_0007}) begin n_fail++;
         $display("FAIL trap_mcause got %h exp %h", {rv, er, rd}, {2'b10, 32'h8000_0007}); end
      do_csr(2'b00, 12'h343, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0000_DEAD}) begin n_fail++;
         $display("FAIL trap_mtval got %h exp %h", {rv, er, rd}, {2'b10, 32'h0000_DEAD}); end
   endtask

   task automatic test_trap_write_mret();
      do_csr(2'b01, 12'h300, 32'h0000_0008, rv, er, rd);
      do_csr(2'b01, 12'h340, 32'h0000_1111, rv, er, rd);
      @(negedge clk_i);
      csr_req_i = 1'b1; csr_op_i = 2'b01; csr_addr_i = 12'h340; csr_wdata_i = 32'h2222;
      trap_i = 1'b1; trap_cause_i = 32'h2; trap_pc_i = 32'h200; trap_tval_i = 32'h0;
      @(negedge clk_i);
      n_tests++; if ({csr_rvalid_o, csr_err_o, csr_rdata_o} !== {2'b10, 32'h1111}) begin n_fail++;
         $display("FAIL trap_write_resp got %h exp %h", {csr_rvalid_o, csr_err_o, csr_rdata_o}, {2'b10, 32'h1111}); end
      csr_req_i = 1'b0; csr_op_i = 2'b00; csr_wdata_i = '0; trap_i = 1'b0; trap_cause_i = '0;
      do_csr(2'b00, 12'h340, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h1111}) begin n_fail++;
         $display("FAIL trap_write_suppressed got %h exp %h", {rv, er, rd}, {2'b10, 32'h1111}); end
      @(negedge clk_i);
      mret_i = 1'b1;
      @(negedge clk_i);
      mret_i = 1'b0;
      do_csr(2'b00, 12'h300, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0000_1888}) begin n_fail++;
         $display("FAIL mret_mstatus got %h exp %h", {rv, er, rd}, {2'b10, 32'h0000_1888}); end
      n_tests++; if ({irq_pending_o, mepc_o} !== {1'b1, 32'h200}) begin n_fail++;
         $display("FAIL mret_irq_mepc got %h exp %h", {irq_pending_o, mepc_o}, {1'b1, 32'h200}); end
   endtask

   task automatic test_errors();
      do_csr(2'b01, 12'hF14, 32'hFFFF_FFFF, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b11, 32'h0}) begin n_fail++;
         $display("FAIL err_mhartid_write got %h exp %h", {rv, er, rd}, {2'b11, 32'h0}); end
      do_csr(2'b00, 12'hF14, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'd5}) begin n_fail++;
         $display("FAIL err_mhartid_kept got %h exp %h", {rv, er, rd}, {2'b10, 32'd5}); end
      do_csr(2'b01, 12'h7C0, 32'hFFFF_FFFF, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b11, 32'h0}) begin n_fail++;
         $display("FAIL err_unmapped got %h exp %h", {rv, er, rd}, {2'b11, 32'h0}); end
      do_csr(2'b10, 12'hC00, 32'hFFFF_FFFF, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b11, 32'h0}) begin n_fail++;
         $display("FAIL err_cycle_set got %h exp %h", {rv, er, rd}, {2'b11, 32'h0}); end
      do_csr(2'b00, 12'h340, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h1111}) begin n_fail++;
         $display("FAIL err_no_state_change got %h exp %h", {rv, er, rd}, {2'b10, 32'h1111}); end
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk_i);
      csr_req_i = 1'b1; csr_op_i = 2'b00; csr_addr_i = 12'hF14;
      @(posedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      n_tests++; if ({csr_rvalid_o, csr_err_o, csr_rdata_o} !== 34'd0) begin n_fail++;
         $display("FAIL reset_mid_op got %h exp %h", {csr_rvalid_o, csr_err_o, csr_rdata_o}, 34'd0); end
      csr_req_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      do_csr(2'b00, 12'h340, 32'h0, rv, er, rd);
      n_tests++; if ({rv, er, rd} !== {2'b10, 32'h0}) begin n_fail++;
         $display("FAIL reset_mscratch got %h exp %h", {rv, er, rd}, {2'b10, 32'h0}); end
   endtask

   initial begin
      test_reset();
      test_mscratch();
      test_warl();
      test_back_to_back_mcycle();
      test_minstret();
      test_irq_trap();
      test_trap_write_mret();
      test_errors();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
